pixel_fb_writer: RTL
====================

# pixel_fb_writer

Downstream consumer of the screen-fill pixel generator: accepts the per-pixel stream (x, y, 3-bit colour, plot strobe) and turns it into linear framebuffer writes at address y*H_RES + x. It registers the address computation, buffers pixels in a small FIFO so the memory port may stall, and back-pressures the generator through `pix_ready`, which the generator ANDs into its `plot` enable. It also flags completion of a full frame.

## Interface
- NX, 8, width of x coordinate
- NY, 7, width of y coordinate
- H_RES, 160, pixels per line
- V_RES, 120, lines per frame
- AW, 15, framebuffer address width; must satisfy 2^AW ≥ H_RES*V_RES
- FIFO_DEPTH, 4, write-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pix_valid  in  1  pixel present (generator `plot`)
- pix_x  in  NX  pixel x
- pix_y  in  NY  pixel y
- pix_color  in  3  pixel colour
- pix_ready  out  1  block can accept a pixel this cycle
- mem_we  out  1  write request to framebuffer
- mem_addr  out  AW  write address
- mem_data  out  3  write colour
- mem_ready  in  1  framebuffer accepts write this cycle
- frame_done  out  1  one-cycle pulse after last frame address written

## Operation
- Accept: pixel accepted on a cycle with pix_valid && pix_ready.
- Stage 1 (registered): s1_valid, s1_addr = pix_y*H_RES + pix_x (computed at AW bits, no truncation below AW), s1_color.
- Stage 2: s1 contents pushed into FIFO the following cycle whenever s1_valid.
- Write port: mem_we = FIFO not empty; mem_addr/mem_data = FIFO head; pop on mem_we && mem_ready. Strict in-order, no reordering or merging.
- pix_ready = (fifo_count + s1_valid) < FIFO_DEPTH; combinational from registers only (no path from pix_valid or mem_ready).
- Simultaneous push and pop in the same cycle: count unchanged, legal even when FIFO is full.
- frame_done: registered, asserted the cycle after a pop whose address equals H_RES*V_RES-1; otherwise 0.
- Reset (any time, including mid-burst): s1_valid=0, FIFO empty, pointers 0, mem_we=0, frame_done=0, pix_ready=1 once reset deasserts; mem_addr/mem_data=0. Buffered pixels are discarded.

## Timing
- Pixel accepted on edge N → in s1 after N → in FIFO after N+1 → mem_we high in cycle N+2 (min latency 2).
- Throughput 1 pixel/cycle with mem_ready held high.
- mem_ready low holds head stable; mem_addr/mem_data must not change while mem_we=1 and not accepted.
- frame_done one cycle after the accepting edge of address 19199 (default parameters).

## Configuration
- PIX_CLIP_EN defined: pixels with pix_x ≥ H_RES or pix_y ≥ V_RES are accepted (consume handshake) but never enter s1/FIFO; extra output `clip_count` (16 bit, saturating, reset 0) increments per dropped pixel.
- Not defined: no range check, no `clip_count` port; out-of-range coordinates are written at the computed address modulo 2^AW.

## Structure
- Shared package `fb_pkg`: H_RES, V_RES, FB_SIZE (=H_RES*V_RES), AW, colour typedef `color_t` (logic [2:0]), struct `fb_wr_t` {addr, color}.
- One sub-module: `fb_wr_fifo` (synchronous FIFO of fb_wr_t, count output, simultaneous push/pop).
- Address multiply implemented as shift-add for H_RES=160: (y<<7)+(y<<5)+x.

## Test plan
- Single pixel x=3, y=2, colour=5, mem_ready=1 → mem_we in cycle +2, mem_addr=323, mem_data=5, one cycle only.
- mem_ready=0, pix_valid held with 6 pixels → exactly 4 accepted, pix_ready=0; release mem_ready → 4 writes in original order, then remaining 2.
- Full frame raster 0..159 × 0..119, mem_ready=1 → 19200 writes, consecutive addresses 0..19199, single frame_done pulse after 19199.
- Random mem_ready toggling with continuous input → no lost/duplicated writes, scoreboard match, mem_addr stable while stalled.
- Reset asserted with FIFO holding 3 entries → mem_we=0 immediately, no further writes, pix_ready=1 after release.
- PIX_CLIP_EN: pixel x=160, y=0 → no write, clip_count=1; without macro → write at address 160.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer writer: the frame geometry, the
// coordinate and address widths, the colour type, the write-record struct,
// and the helper that turns a pixel coordinate into a linear address.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int NX      = 8;              // x coordinate width
    localparam int NY      = 7;              // y coordinate width
    localparam int H_RES   = 160;            // pixels per line
    localparam int V_RES   = 120;            // lines per frame
    localparam int FB_SIZE = H_RES * V_RES;  // pixels per frame
    localparam int AW      = 15;             // framebuffer address width

    typedef logic [2:0] color_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        color_t        color;
    } fb_wr_t;

    // Linear address y*H_RES + x, evaluated at the full AW width.
    // For the 160-pixel line the multiply is 128y + 32y, so it reduces to
    // two shifted copies of y plus x. Other line lengths fall back to a
    // generic multiply. Coordinates outside the frame wrap modulo 2^AW.
    function automatic logic [AW-1:0] pix_addr(input logic [NX-1:0] x,
                                                input logic [NY-1:0] y);
        logic [AW-1:0] ye;
        logic [AW-1:0] xe;
        ye = AW'(y);
        xe = AW'(x);
        if (H_RES == 160)
            return (ye << 7) + (ye << 5) + xe;
        else
            return ye * AW'(H_RES) + xe;
    endfunction

endpackage

// File: rtl/pixel_fb_writer_if.sv
// -----------------------------------------------------------------------------
// pixel_fb_writer_if
// Bundles the pixel stream coming from the generator and the write port
// going to the framebuffer.
//   pix_valid/pix_x/pix_y/pix_color : pixel offered by the generator
//   pix_ready                        : writer can take a pixel this cycle
//   mem_we/mem_addr/mem_data         : framebuffer write request
//   mem_ready                        : framebuffer accepts the write
//   frame_done                       : pulse after the last frame address
// Modports: master = environment (generator and memory), slave = writer.
// -----------------------------------------------------------------------------
interface pixel_fb_writer_if;
    import fb_pkg::*;

    logic          pix_valid;
    logic [NX-1:0] pix_x;
    logic [NY-1:0] pix_y;
    color_t        pix_color;
    logic          pix_ready;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    color_t        mem_data;
    logic          mem_ready;

    logic          frame_done;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, mem_ready,
        input  pix_ready, mem_we, mem_addr, mem_data, frame_done
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, mem_ready,
        output pix_ready, mem_we, mem_addr, mem_data, frame_done
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous FIFO of framebuffer write records. A push and a pop in the
// same cycle leave the count unchanged, and this also holds when the FIFO
// is full.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : record to store
//   pop        : drop the head record
//   head       : record at the head, meaningful only while !empty
//   empty      : no records stored
//   count      : number of records stored (0..DEPTH)
// -----------------------------------------------------------------------------
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4  // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fb_wr_t                   push_data,
    input  logic                     pop,
    output fb_wr_t                   head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fb_wr_t        storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // NOTE: the storage array has no reset; reset only clears the pointers
    // and count, so stale entries are never visible as valid data.
    always_ff @(posedge clk) begin
        if (do_push)
            storage[wr_ptr] <= push_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;   // DEPTH is a power of two, wraps naturally
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// -----------------------------------------------------------------------------
// pixel_fb_writer
// Turns the generator's pixel stream into linear framebuffer writes at
// y*H_RES + x. One register stage computes the address, a small FIFO lets
// the memory stall, and pix_ready back-pressures the generator. frame_done
// pulses the cycle after the last frame address is written.
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : pixel stream in, framebuffer write port out, frame_done
//   clip_count  : (PIX_CLIP_EN only) saturating count of dropped pixels
// Build option: define PIX_CLIP_EN to drop pixels outside the frame
// (they still complete the handshake) and count them in clip_count.
// Without it there is no range check and out-of-frame pixels are written
// at the computed address modulo 2^AW.
// -----------------------------------------------------------------------------
module pixel_fb_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4  // power of two, >= 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_fb_writer_if.slave     bus
`ifdef PIX_CLIP_EN
    ,
    output logic [15:0]          clip_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          accept;
    logic          in_range;
    logic          s1_load;
    logic          s1_valid;
    fb_wr_t        s1_data;
    fb_wr_t        head;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    // The register stage is counted as occupied space, so whatever is in
    // flight always fits in the FIFO. Depends only on registers.
    assign bus.pix_ready = (fifo_count + CW'(s1_valid)) < CW'(FIFO_DEPTH);
    assign accept        = bus.pix_valid && bus.pix_ready;

`ifdef PIX_CLIP_EN
    assign in_range = (int'(bus.pix_x) < H_RES) && (int'(bus.pix_y) < V_RES);
`else
    assign in_range = 1'b1;
`endif

    assign s1_load = accept && in_range;

    // Address stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_data.addr  <= pix_addr(bus.pix_x, bus.pix_y);
                s1_data.color <= bus.pix_color;
            end
        end
    end

`ifdef PIX_CLIP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clip_count <= '0;
        else if (accept && !in_range && (clip_count != 16'hFFFF))
            clip_count <= clip_count + 16'd1;
    end
`endif

    fb_wr_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s1_valid),
        .push_data (s1_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The head is forced to zero while empty so the port shows no stale
    // data after reset; while a write waits the head cannot change.
    assign bus.mem_we   = !fifo_empty;
    assign bus.mem_addr = fifo_empty ? '0 : head.addr;
    assign bus.mem_data = fifo_empty ? '0 : head.color;
    assign pop          = bus.mem_we && bus.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.frame_done <= 1'b0;
        else
            bus.frame_done <= pop && (head.addr == AW'(FB_SIZE - 1));
    end

endmodule
